// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID->EX pipeline register for the 5-stage RV32I core.
//   - Captures regfile operands, immediate, PC, source/destination indices and
//     the decoded control bundle of the instruction currently in ID.
//   - WB->ID bypass: the regfile writes on the clock edge, so a read in the
//     same cycle as a WB write returns stale data; the WB value is muxed in.
//   - Load-use hazard detection: stalls IF/ID and injects one bubble.
//   - Honours EX hold (freeze) and branch flush (kill the ID instruction).
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   id_*                       instruction fields from ID
//   rf_rdata1/2                regfile read data for id_rs1/id_rs2
//   wb_reg_write/wb_rd/wb_data WB-stage regfile write port (bypass source)
//   ex_hold, flush             EX back-pressure and branch-taken kill
//   stall_id                   hold PC and IF/ID register this cycle
//   ex_*                       registered EX-stage instruction
//   bubble_cnt                 saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic [CNT_W-1:0]  bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic            byp1;
  logic            byp2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            haz;

  // ID side: bypass and hazard detection (combinational)
  // wb_rd==0 never bypasses: x0 writes are discarded by the regfile.
  assign byp1 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1);
  assign byp2 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2);
  assign op1  = byp1 ? wb_data : rf_rdata1;
  assign op2  = byp2 ? wb_data : rf_rdata2;

  assign haz = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (ex_rd == id_rs1)) ||
                (id_use_rs2 && (ex_rd == id_rs2)));

  // Forced low during reset so the front end is not frozen by a stale ex_hold.
  assign stall_id = !reset && !flush && (ex_hold || haz);

  // ID -> EX register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= '0;
      ex_mem_read <= 1'b0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_mem_read <= 1'b0;
    end else if (ex_hold) begin
      // EX frozen; a pending hazard is re-evaluated once the hold lifts.
    end else if (haz) begin
      // Clearing ex_mem_read drops haz next cycle, so one bubble suffices.
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_mem_read <= 1'b0;
      bubble_cnt  <= sat_inc(bubble_cnt);
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      ex_rs1_data <= op1;
      ex_rs2_data <= op2;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_mem_read <= id_valid && id_mem_read;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;
  localparam int CNT_W  = 16;
  localparam int SMALL_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              id_valid = 1'b0;
  logic [XLEN-1:0]   id_pc = '0;
  logic [4:0]        id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic              id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [XLEN-1:0]   id_imm = '0;
  logic [CTRL_W-1:0] id_ctrl = '0;
  logic              id_mem_read = 1'b0;
  logic [XLEN-1:0]   rf_rdata1 = '0, rf_rdata2 = '0;
  logic              wb_reg_write = 1'b0;
  logic [4:0]        wb_rd = '0;
  logic [XLEN-1:0]   wb_data = '0;
  logic              ex_hold = 1'b0;
  logic              flush = 1'b0;

  logic              stall_id, ex_valid, ex_mem_read;
  logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  // Second instance with a narrow counter so saturation is reachable quickly.
  logic              s_stall_id, s_ex_valid, s_ex_mem_read;
  logic [XLEN-1:0]   s_ex_pc, s_ex_imm, s_ex_rs1_data, s_ex_rs2_data;
  logic [4:0]        s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [CTRL_W-1:0] s_ex_ctrl;
  logic [SMALL_W-1:0] s_bubble_cnt;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_hold(ex_hold), .flush(flush),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(SMALL_W)) dut_s (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_hold(ex_hold), .flush(flush),
    .stall_id(s_stall_id), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_imm(s_ex_imm),
    .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_rs1(s_ex_rs1),
    .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_ctrl(s_ex_ctrl), .ex_mem_read(s_ex_mem_read),
    .bubble_cnt(s_bubble_cnt)
  );

  // ---------------- reference model ----------------
  // Contents of the EX slot as the rules describe them; m_known says whether
  // the datapath fields hold a defined value (flush/bubble leave them open).
  bit              m_valid = 0, m_mr = 0, m_known = 1;
  logic [XLEN-1:0] m_pc = '0, m_imm = '0, m_d1 = '0, m_d2 = '0;
  logic [4:0]      m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [CTRL_W-1:0] m_ctrl = '0;
  int              m_cnt = 0, m_cnt_s = 0;

  function automatic bit model_haz();
    if (!(id_valid && m_valid && m_mr) || m_rd == 5'd0) return 1'b0;
    return (id_use_rs1 && m_rd == id_rs1) || (id_use_rs2 && m_rd == id_rs2);
  endfunction

  function automatic bit model_stall();
    return !reset && !flush && (ex_hold || model_haz());
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (wb_reg_write && rs != 5'd0 && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_mr = 0; m_known = 1; m_pc = '0; m_imm = '0; m_d1 = '0; m_d2 = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_cnt = 0; m_cnt_s = 0;
    end else if (flush) begin
      m_valid = 0; m_mr = 0; m_ctrl = '0; m_known = 0;
    end else if (ex_hold) begin
      m_valid = m_valid;
    end else if (model_haz()) begin
      m_valid = 0; m_mr = 0; m_ctrl = '0; m_known = 0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < (1 << SMALL_W) - 1) m_cnt_s++;
    end else begin
      m_d1 = operand(id_rs1, rf_rdata1);
      m_d2 = operand(id_rs2, rf_rdata2);
      m_valid = id_valid; m_pc = id_pc; m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2;
      m_rd = id_rd; m_ctrl = id_valid ? id_ctrl : '0; m_mr = id_valid && id_mem_read;
      m_known = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One compare process, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_id", 32'(stall_id), 32'(model_stall()));
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
      chk("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
      if (m_known) begin
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_rs1_data", ex_rs1_data, m_d1);
        chk("ex_rs2_data", ex_rs2_data, m_d2);
        chk("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
        chk("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
        chk("ex_rd", 32'(ex_rd), 32'(m_rd));
      end
      chk("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
      chk("bubble_cnt_small", 32'(s_bubble_cnt), 32'(m_cnt_s));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = '0; id_imm = '0; id_ctrl = '0; id_mem_read = 0; rf_rdata1 = '0; rf_rdata2 = '0;
    wb_reg_write = 0; wb_rd = '0; wb_data = '0; ex_hold = 0; flush = 0;
  endtask

  task automatic rand_inputs();
    id_valid     = ($urandom_range(0, 9) != 0);
    id_pc        = $urandom;
    id_rs1       = 5'($urandom_range(0, 7));
    id_rs2       = 5'($urandom_range(0, 7));
    id_use_rs1   = 1'($urandom_range(0, 1));
    id_use_rs2   = 1'($urandom_range(0, 1));
    id_rd        = 5'($urandom_range(0, 7));
    id_imm       = $urandom;
    id_ctrl      = 12'($urandom);
    id_mem_read  = ($urandom_range(0, 9) < 4);
    rf_rdata1    = $urandom;
    rf_rdata2    = $urandom;
    wb_reg_write = 1'($urandom_range(0, 1));
    wb_rd        = 5'($urandom_range(0, 7));
    wb_data      = $urandom;
    ex_hold      = ($urandom_range(0, 9) == 0);
    flush        = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    // 1: reset held with random inputs (including ex_hold) -> everything zero
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      if (i == 0) begin ex_hold = 1; flush = 0; end
      @(negedge clk);
      chk("rst_stall", 32'(stall_id), 32'h0);
      chk("rst_valid", 32'(ex_valid), 32'h0);
      chk("rst_pc", ex_pc, 32'h0);
      chk("rst_rs1_data", ex_rs1_data, 32'h0);
      chk("rst_ctrl", 32'(ex_ctrl), 32'h0);
      chk("rst_mem_read", 32'(ex_mem_read), 32'h0);
      chk("rst_cnt", 32'(bubble_cnt), 32'h0);
      @(posedge clk);
      #1;
    end
    idle();
    reset = 0;
    chk_en = 1;

    // 2: WB bypass into operand 1, and no bypass for wb_rd=0
    id_valid = 1; id_rs1 = 5; rf_rdata1 = 32'h11; wb_reg_write = 1; wb_rd = 5; wb_data = 32'hAB;
    tick();
    chk("bypass_hit", ex_rs1_data, 32'hAB);
    wb_rd = 0;
    tick();
    chk("bypass_x0", ex_rs1_data, 32'h11);

    // 3: lw x7 then add x8,x7,x1 -> one bubble, then add captured
    idle();
    id_valid = 1; id_rd = 7; id_mem_read = 1; id_ctrl = 12'h001; id_pc = 32'h40;
    tick();
    id_rd = 8; id_rs1 = 7; id_use_rs1 = 1; id_rs2 = 1; id_use_rs2 = 1;
    id_mem_read = 0; id_ctrl = 12'h002; id_pc = 32'h44;
    @(negedge clk);
    chk("lu_stall", 32'(stall_id), 32'h1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
    chk("lu_bubble_ctrl", 32'(ex_ctrl), 32'h0);
    chk("lu_cnt", 32'(bubble_cnt), 32'h1);
    @(negedge clk);
    chk("lu_stall_released", 32'(stall_id), 32'h0);
    tick();
    chk("lu_captured_valid", 32'(ex_valid), 32'h1);
    chk("lu_captured_rd", 32'(ex_rd), 32'h8);
    chk("lu_captured_pc", ex_pc, 32'h44);

    // 4: load-use hazard together with flush -> no stall, no bubble counted
    idle();
    id_valid = 1; id_rd = 7; id_mem_read = 1; id_ctrl = 12'h001;
    tick();
    id_rd = 8; id_rs1 = 7; id_use_rs1 = 1; id_mem_read = 0; flush = 1;
    @(negedge clk);
    chk("flush_stall", 32'(stall_id), 32'h0);
    tick();
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_cnt", 32'(bubble_cnt), 32'h1);

    // 5: hold freezes EX for 3 cycles, then the ID instruction is captured
    idle();
    id_valid = 1; id_pc = 32'h100; id_ctrl = 12'h003; id_rd = 3;
    tick();
    chk("hold_pre_pc", ex_pc, 32'h100);
    id_pc = 32'h200; id_ctrl = 12'h005; ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_stall", 32'(stall_id), 32'h1);
      tick();
      chk("hold_pc", ex_pc, 32'h100);
      chk("hold_ctrl", 32'(ex_ctrl), 32'h003);
    end
    ex_hold = 0;
    tick();
    chk("hold_release_pc", ex_pc, 32'h200);

    // 6: repeated lw x7,0(x7): one hazard every two cycles; small counter saturates
    idle();
    id_valid = 1; id_rd = 7; id_rs1 = 7; id_use_rs1 = 1; id_mem_read = 1; id_ctrl = 12'h004;
    repeat (80) tick();
    chk("sat_cnt_wide", 32'(bubble_cnt), 32'd41);
    chk("sat_cnt_small", 32'(s_bubble_cnt), 32'd31);

    // Randomized traffic against the model, with occasional async reset
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
